// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
//   Shared constants for the button conditioner:
//   - 2-bit FSM state encodings (IDLE, FIRE, DELAY, REPEAT/HOLD)
//   - bit positions of the four buttons in every {R,U,D,L} vector
//   - idle level of a raw (active-low) button line
//   - prio_pick(): one-hot select of the highest-priority request, R > U > D > L
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRE   = 2'd1;
  localparam logic [1:0] ST_DELAY  = 2'd2;
  // REPEAT exists only with auto-repeat; HOLD only without it, so they share a code.
  localparam logic [1:0] ST_REPEAT = 2'd3;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int BTN_R = 3;
  localparam int BTN_U = 2;
  localparam int BTN_D = 1;
  localparam int BTN_L = 0;

  // Raw buttons are active low, so an unpressed line reads 1.
  localparam logic RAW_IDLE = 1'b1;

  function automatic logic [3:0] prio_pick(input logic [3:0] req);
    logic [3:0] win;
    win = 4'b0000;
    if (req[BTN_R])      win[BTN_R] = 1'b1;
    else if (req[BTN_U]) win[BTN_U] = 1'b1;
    else if (req[BTN_D]) win[BTN_D] = 1'b1;
    else if (req[BTN_L]) win[BTN_L] = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One button channel: 2-flop synchronizer followed by a stable-sample
//   counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive
//   samples that disagree with it; any agreeing sample clears the count.
//
//   Ports:
//     clk   in   player clock, posedge
//     rst   in   asynchronous active-high reset
//     raw   in   raw button line, active low, asynchronous to clk
//     held  out  debounced level, 1 = pressed
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [CW-1:0] cnt;

  assign sample = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sample == held) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        held <= ~held;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Turns four raw, bouncy, active-low buttons {R,U,D,L} into clean
//   single-cycle, one-hot, active-low move pulses for the player logic.
//
//   Ports:
//     clk      in   player slow clock, posedge
//     rst      in   asynchronous active-high reset
//     btn_raw  in   [3:0] raw buttons {R,U,D,L}, low active, asynchronous
//     btn      out  [3:0] move request {R,U,D,L}, low active, one-hot, 1 cycle
//     held     out  [3:0] debounced levels {R,U,D,L}, high = pressed
//
//   Build option BTN_AUTO_REPEAT_EN:
//     defined   - holding the latched direction repeats the pulse, first after
//                 REPEAT_DELAY+1 cycles, then every REPEAT_PERIOD+1 cycles.
//     undefined - one pulse per press; no repeat counter exists and the
//                 REPEAT_* parameters have no effect.
//
//   The FSM state is kept in the 'state' signal for hierarchical observation.
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn,
  output logic [3:0] held
);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [3:0] dir;
  logic [3:0] dir_nx;
  logic [3:0] held_prev;
  logic [3:0] rise;
  logic [3:0] pend;
  logic [3:0] evt_idle;
  logic [3:0] evt_other;
  logic [3:0] clr;
  logic       dir_held;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          rep;
  logic          rep_nx;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nx;
  logic [RW-1:0] rthr;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (btn_raw[i]),
      .held(held[i])
    );
  end

  assign rise     = held & ~held_prev;
  // IDLE also sees presses that arrived while another direction was active
  // (simultaneous losers, or a press in the same cycle as a release).
  assign evt_idle = pend | rise;
  // While a direction is active only fresh presses of other buttons take over;
  // older pending presses wait until the active button is released.
  assign evt_other = rise & ~dir;
  assign dir_held  = |(held & dir);

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    clr      = 4'b0000;
`ifdef BTN_AUTO_REPEAT_EN
    rep_nx   = rep;
    rcnt_nx  = rcnt;
    rthr     = (state == ST_REPEAT) ? PERIOD_LAST : DELAY_LAST;
`endif
    case (state)
      ST_IDLE: begin
        if (|evt_idle) begin
          dir_nx   = prio_pick(evt_idle);
          clr      = dir_nx;
          state_nx = ST_FIRE;
`ifdef BTN_AUTO_REPEAT_EN
          rep_nx   = 1'b0;
`endif
        end
      end
      ST_FIRE: begin
`ifdef BTN_AUTO_REPEAT_EN
        rcnt_nx  = '0;
        state_nx = rep ? ST_REPEAT : ST_DELAY;
`else
        state_nx = ST_HOLD;
`endif
      end
`ifdef BTN_AUTO_REPEAT_EN
      ST_DELAY, ST_REPEAT: begin
        if (!dir_held) begin
          state_nx = ST_IDLE;
        end else if (|evt_other) begin
          dir_nx   = prio_pick(evt_other);
          clr      = dir_nx;
          rep_nx   = 1'b0;
          state_nx = ST_FIRE;
        end else if (rcnt == rthr) begin
          rep_nx   = 1'b1;
          state_nx = ST_FIRE;
        end else if (rcnt != {RW{1'b1}}) begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
`else
      ST_HOLD: begin
        if (!dir_held) begin
          state_nx = ST_IDLE;
        end else if (|evt_other) begin
          dir_nx   = prio_pick(evt_other);
          clr      = dir_nx;
          state_nx = ST_FIRE;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= 4'b0000;
      held_prev <= 4'b0000;
      pend      <= 4'b0000;
      btn       <= 4'b1111;
`ifdef BTN_AUTO_REPEAT_EN
      rep       <= 1'b0;
      rcnt      <= '0;
`endif
    end else begin
      state     <= state_nx;
      dir       <= dir_nx;
      held_prev <= held;
      // A pending press is dropped once consumed or once its button is released.
      pend      <= (pend | rise) & held & ~clr;
      // Registered so the pulse coincides exactly with the FIRE cycle.
      btn       <= (state_nx == ST_FIRE) ? ~dir_nx : 4'b1111;
`ifdef BTN_AUTO_REPEAT_EN
      rep       <= rep_nx;
      rcnt      <= rcnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=5. Every pulse seen on btn is logged as {cycle, btn}; each
//   scenario queues the pulses it expects (hand-computed cycle numbers) and
//   compares both queues. Cycle n means "after posedge n"; inputs change on
//   the negedge, so a change made at cycle c is first sampled at edge c+1.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn;
  logic [3:0] held;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c;
  int r;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .btn    (btn),
    .held   (held)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pw(input int t, input logic [3:0] b);
    logic [27:0] tt;
    tt = t[27:0];
    return {tt, b};
  endfunction

  // pulse monitor
  always @(negedge clk) begin
    if (btn !== 4'b1111) obs_q.push_back(pw(cyc, btn));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check(tag, obs_q.pop_front(), exp_q.pop_front());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // reset with buttons idle
    rst     = 1'b1;
    btn_raw = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_btn", btn, 4'b1111);
    check("rst_held", held, 4'b0000);
    rst = 1'b0;
    c = cyc;
    step_to(c + 20);
    check("idle_btn", btn, 4'b1111);
    check("idle_held", held, 4'b0000);
    drain("idle_pulses");

    // U pressed for 8 cycles
    c = cyc;
    btn_raw = 4'b1011;
    step_to(c + 5);
    check("u_held_pre", held, 4'b0000);
    step_to(c + 6);
    check("u_held_set", held, 4'b0100);
    exp_q.push_back(pw(c + 7, 4'b1011));
    step_to(c + 8);
    btn_raw = 4'b1111;
    step_to(c + 13);
    check("u_held_still", held, 4'b0100);
    step_to(c + 14);
    check("u_held_clr", held, 4'b0000);
    step_to(c + 30);
    drain("u_pulse");

    // U glitch of 3 cycles
    c = cyc;
    btn_raw = 4'b1011;
    step_to(c + 3);
    btn_raw = 4'b1111;
    step_to(c + 5);
    check("glitch_held5", held, 4'b0000);
    step_to(c + 6);
    check("glitch_held6", held, 4'b0000);
    step_to(c + 20);
    drain("glitch_pulses");

    // R and L together; L fires after R is released
    c = cyc;
    btn_raw = 4'b0110;
    step_to(c + 6);
    check("rl_held", held, 4'b1001);
    exp_q.push_back(pw(c + 7, 4'b0111));
    step_to(c + 9);
    btn_raw = 4'b1110;
    step_to(c + 16);
    check("rl_held_l", held, 4'b0001);
    exp_q.push_back(pw(c + 17, 4'b1110));
    step_to(c + 20);
    btn_raw = 4'b1111;
    step_to(c + 40);
    drain("rl_pulses");

    // D held for 40 cycles
    c = cyc;
    btn_raw = 4'b1101;
    exp_q.push_back(pw(c + 7, 4'b1101));
`ifdef BTN_AUTO_REPEAT_EN
    exp_q.push_back(pw(c + 18, 4'b1101));
    exp_q.push_back(pw(c + 24, 4'b1101));
    exp_q.push_back(pw(c + 30, 4'b1101));
    exp_q.push_back(pw(c + 36, 4'b1101));
    exp_q.push_back(pw(c + 42, 4'b1101));
`endif
    step_to(c + 40);
    btn_raw = 4'b1111;
    step_to(c + 60);
    drain("d_repeat");

    // reset during the FIRE cycle with U held
    c = cyc;
    btn_raw = 4'b1011;
    exp_q.push_back(pw(c + 7, 4'b1011));
    step_to(c + 7);
    #1;
    check("fire_btn", btn, 4'b1011);
    rst = 1'b1;
    #1;
    check("async_rst_btn", btn, 4'b1111);
    check("async_rst_held", held, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back(pw(r + 7, 4'b1011));
    step_to(r + 8);
    btn_raw = 4'b1111;
    step_to(r + 30);
    check("end_btn", btn, 4'b1111);
    check("end_held", held, 4'b0000);
    drain("rst_repress");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
